// File: rtl/mmio_requester.sv
// mmio_requester
//   Host-side MMIO initiator. It takes one read/write command at a time and
//   turns it into a single-cycle MMIO request pulse towards an AFU. Read
//   responses are matched by TID, and each command ends in one completion on
//   a valid/ready channel. A read that gets no matching response in time
//   completes with a timeout. AFU responses that match no pending read are
//   counted in a saturating stray counter.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   cmd_valid/ready     command handshake (ready only in IDLE)
//   cmd_write           1 = write, 0 = read
//   cmd_addr            32-bit word address (64-bit registers at even addresses)
//   cmd_wdata           write data
//   req_mmio_wr_valid   one-cycle write request pulse
//   req_mmio_rd_valid   one-cycle read request pulse
//   req_addr/tid/data   request fields, valid while a pulse is high
//   afu_rd_valid/tid/data  AFU read response
//   rsp_valid/ready     completion handshake
//   rsp_data            read data (0 for writes, errors, timeouts)
//   rsp_timeout         read timed out
//   rsp_error           command rejected (odd address)
//   stray_cnt           saturating count of unmatched AFU responses
module mmio_requester #(
  parameter int TIMEOUT_CYCLES = 256,
  parameter int TID_W          = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [15:0]      cmd_addr,
  input  logic [63:0]      cmd_wdata,
  output logic             req_mmio_wr_valid,
  output logic             req_mmio_rd_valid,
  output logic [15:0]      req_addr,
  output logic [TID_W-1:0] req_tid,
  output logic [63:0]      req_data,
  input  logic             afu_rd_valid,
  input  logic [TID_W-1:0] afu_rd_tid,
  input  logic [63:0]      afu_rd_data,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [63:0]      rsp_data,
  output logic             rsp_timeout,
  output logic             rsp_error,
  output logic [15:0]      stray_cnt
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [15:0]      TIMER_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [TID_W-1:0] TID_ONE    = {{(TID_W-1){1'b0}}, 1'b1};

  state_t           state;
  logic [TID_W-1:0] tid_cnt;   // next TID to hand out
  logic [TID_W-1:0] cur_tid;   // TID of the read in flight
  logic [15:0]      timer;     // cycles spent in WAIT
  logic             tid_match;
  logic             stray_hit;

  // A response only completes a read while waiting and with the right TID;
  // every other response is stray.
  assign tid_match = afu_rd_valid && (state == WAIT) && (afu_rd_tid == cur_tid);
  assign stray_hit = afu_rd_valid && !tid_match;

  assign cmd_ready = (state == IDLE);

  // Command FSM, request pulses, completion registers and stray counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      tid_cnt           <= '0;
      cur_tid           <= '0;
      timer             <= 16'd0;
      req_mmio_wr_valid <= 1'b0;
      req_mmio_rd_valid <= 1'b0;
      req_addr          <= 16'd0;
      req_tid           <= '0;
      req_data          <= 64'd0;
      rsp_valid         <= 1'b0;
      rsp_data          <= 64'd0;
      rsp_timeout       <= 1'b0;
      rsp_error         <= 1'b0;
      stray_cnt         <= 16'd0;
    end else begin
      if (stray_hit && (stray_cnt != 16'hFFFF)) begin
        stray_cnt <= stray_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_addr[0]) begin
              // Odd address: reject without touching the AFU or the TIDs.
              state       <= DONE;
              rsp_valid   <= 1'b1;
              rsp_error   <= 1'b1;
              rsp_timeout <= 1'b0;
              rsp_data    <= 64'd0;
            end else begin
              // Request fields are loaded here so they are registered
              // outputs during the single ISSUE cycle.
              state             <= ISSUE;
              req_mmio_wr_valid <= cmd_write;
              req_mmio_rd_valid <= !cmd_write;
              req_addr          <= cmd_addr;
              req_tid           <= tid_cnt;
              req_data          <= cmd_write ? cmd_wdata : 64'd0;
              cur_tid           <= tid_cnt;
            end
          end
        end

        ISSUE: begin
          req_mmio_wr_valid <= 1'b0;
          req_mmio_rd_valid <= 1'b0;
          req_addr          <= 16'd0;
          req_tid           <= '0;
          req_data          <= 64'd0;
          if (req_mmio_rd_valid) begin
            state   <= WAIT;
            timer   <= 16'd0;
            tid_cnt <= tid_cnt + TID_ONE;
          end else begin
            state       <= DONE;
            rsp_valid   <= 1'b1;
            rsp_data    <= 64'd0;
            rsp_timeout <= 1'b0;
            rsp_error   <= 1'b0;
          end
        end

        WAIT: begin
          // A match on the expiry cycle wins over the timeout.
          if (tid_match) begin
            state       <= DONE;
            rsp_valid   <= 1'b1;
            rsp_data    <= afu_rd_data;
            rsp_timeout <= 1'b0;
            rsp_error   <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            state       <= DONE;
            rsp_valid   <= 1'b1;
            rsp_data    <= 64'd0;
            rsp_timeout <= 1'b1;
            rsp_error   <= 1'b0;
          end else begin
            timer <= timer + 16'd1;
          end
        end

        DONE: begin
          if (rsp_ready) begin
            state       <= IDLE;
            rsp_valid   <= 1'b0;
            rsp_data    <= 64'd0;
            rsp_timeout <= 1'b0;
            rsp_error   <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mmio_requester.sv
// Directed plus randomized bench for mmio_requester. The bench plays the
// AFU responder itself, keeps a register-map model (associative array), and
// tracks the expected TID counter and stray count arithmetically.
module tb_mmio_requester;

  localparam int TO    = 8;
  localparam int TID_W = 9;

  logic             clk = 1'b0;
  logic             rst;
  logic             cmd_valid, cmd_ready, cmd_write;
  logic [15:0]      cmd_addr;
  logic [63:0]      cmd_wdata;
  logic             req_mmio_wr_valid, req_mmio_rd_valid;
  logic [15:0]      req_addr;
  logic [TID_W-1:0] req_tid;
  logic [63:0]      req_data;
  logic             afu_rd_valid;
  logic [TID_W-1:0] afu_rd_tid;
  logic [63:0]      afu_rd_data;
  logic             rsp_valid, rsp_ready;
  logic [63:0]      rsp_data;
  logic             rsp_timeout, rsp_error;
  logic [15:0]      stray_cnt;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [63:0]      mem [int];
  int               exp_tid   = 0;
  int               exp_stray = 0;
  logic [TID_W-1:0] last_tid;

  mmio_requester #(.TIMEOUT_CYCLES(TO), .TID_W(TID_W)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .req_mmio_wr_valid(req_mmio_wr_valid), .req_mmio_rd_valid(req_mmio_rd_valid),
    .req_addr(req_addr), .req_tid(req_tid), .req_data(req_data),
    .afu_rd_valid(afu_rd_valid), .afu_rd_tid(afu_rd_tid), .afu_rd_data(afu_rd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_error(rsp_error), .stray_cnt(stray_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic inject(input logic [TID_W-1:0] tid, input logic [63:0] data);
    afu_rd_valid = 1'b1; afu_rd_tid = tid; afu_rd_data = data;
    tick();
    afu_rd_valid = 1'b0; afu_rd_tid = '0; afu_rd_data = 64'd0;
  endtask

  // Offer a command in IDLE; returns one cycle after acceptance.
  task automatic issue_cmd(input logic wr, input logic [15:0] addr, input logic [63:0] wd);
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd;
    tick();
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0; cmd_wdata = 64'd0;
  endtask

  // Hold the completion for 'hold' cycles, then consume it.
  task automatic finish_rsp(input logic [63:0] d, input logic to, input logic er, input int hold);
    for (int h = 0; h < hold; h++) begin
      chk("rsp_hold_valid", rsp_valid, 1);
      chk("rsp_hold_data", rsp_data, d);
      tick();
    end
    chk("rsp_valid", rsp_valid, 1);
    chk("rsp_data", rsp_data, d);
    chk("rsp_timeout", rsp_timeout, to);
    chk("rsp_error", rsp_error, er);
    chk("cmd_ready_busy", cmd_ready, 0);
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    chk("rsp_cleared", rsp_valid, 0);
    chk("rsp_data_cleared", rsp_data, 0);
    chk("cmd_ready_back", cmd_ready, 1);
    chk("stray_cnt", stray_cnt, 64'(exp_stray));
  endtask

  task automatic do_write(input logic [15:0] addr, input logic [63:0] wd, input int hold);
    issue_cmd(1'b1, addr, wd);
    chk("wr_pulse", req_mmio_wr_valid, 1);
    chk("wr_no_rd", req_mmio_rd_valid, 0);
    chk("wr_addr", req_addr, addr);
    chk("wr_data", req_data, wd);
    chk("wr_tid", req_tid, 64'(exp_tid));
    mem[int'(addr)] = wd;
    tick();
    chk("wr_pulse_end", req_mmio_wr_valid, 0);
    finish_rsp(64'd0, 1'b0, 1'b0, hold);
  endtask

  // dly: response cycles after the pulse (1..TO). wrong_first: a TID+1
  // response one cycle after the pulse. silent: no response at all.
  task automatic do_read(input logic [15:0] addr, input int dly, input bit wrong_first,
                         input bit silent, input logic [63:0] rdata, input int hold);
    logic [TID_W-1:0] t;
    issue_cmd(1'b0, addr, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("rd_pulse", req_mmio_rd_valid, 1);
    chk("rd_no_wr", req_mmio_wr_valid, 0);
    chk("rd_addr", req_addr, addr);
    chk("rd_data_zero", req_data, 0);
    chk("rd_tid", req_tid, 64'(exp_tid));
    t = TID_W'(exp_tid);
    last_tid = t;
    exp_tid = (exp_tid + 1) % (1 << TID_W);
    tick();
    chk("rd_pulse_end", req_mmio_rd_valid, 0);
    if (silent) begin
      for (int k = 0; k < TO; k++) begin
        chk("to_wait", rsp_valid, 0);
        tick();
      end
      finish_rsp(64'd0, 1'b1, 1'b0, hold);
    end else begin
      for (int k = 0; k < dly - 1; k++) begin
        chk("rd_wait", rsp_valid, 0);
        if (wrong_first && k == 0) begin
          inject(t + TID_W'(1), ~rdata);
          exp_stray++;
        end else begin
          tick();
        end
      end
      chk("rd_wait_last", rsp_valid, 0);
      inject(t, rdata);
      finish_rsp(rdata, 1'b0, 1'b0, hold);
    end
  endtask

  task automatic do_odd(input logic [15:0] addr, input int hold);
    issue_cmd(1'b0, addr, 64'd0);
    chk("odd_no_rd", req_mmio_rd_valid, 0);
    chk("odd_no_wr", req_mmio_wr_valid, 0);
    finish_rsp(64'd0, 1'b0, 1'b1, hold);
  endtask

  initial begin
    logic [15:0] a;
    logic [63:0] d;
    int          op;

    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'd0; cmd_wdata = 64'd0;
    afu_rd_valid = 1'b0; afu_rd_tid = '0; afu_rd_data = 64'd0; rsp_ready = 1'b0;
    tick(); tick();
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rd_pulse", req_mmio_rd_valid, 0);
    chk("rst_wr_pulse", req_mmio_wr_valid, 0);
    chk("rst_req_tid", req_tid, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_stray", stray_cnt, 0);
    rst = 1'b0;
    tick();
    chk("post_rst_ready", cmd_ready, 1);

    // Basic read, 1-cycle responder
    do_read(16'h0000, 1, 1'b0, 1'b0, 64'h1000_0100_0000_0000, 0);

    // Write then read back through the register model
    do_write(16'h0020, 64'hDEAD_BEEF_0000_0001, 1);
    do_read(16'h0020, 2, 1'b0, 1'b0, mem[32'h20], 0);

    // Silent responder: timeout, then a late response is stray
    do_read(16'h0040, 1, 1'b0, 1'b1, 64'd0, 0);
    tick();
    inject(last_tid, 64'h1234);
    exp_stray++;
    chk("late_stray", stray_cnt, 64'(exp_stray));

    // Wrong TID first, correct TID three cycles later
    do_read(16'h0042, 4, 1'b1, 1'b0, 64'hCAFE_F00D_0000_0042, 2);

    // Odd address rejected; next read shows the TID did not advance
    do_odd(16'h0003, 1);
    do_read(16'h0044, 1, 1'b0, 1'b0, 64'h55, 0);

    // Reset while waiting
    issue_cmd(1'b0, 16'h0046, 64'd0);
    last_tid = req_tid;
    chk("rstw_tid", req_tid, 64'(exp_tid));
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_tid = 0; exp_stray = 0;
    chk("rstw_ready", cmd_ready, 1);
    chk("rstw_rsp", rsp_valid, 0);
    chk("rstw_stray0", stray_cnt, 0);
    inject(last_tid, 64'h99);
    exp_stray = 1;
    chk("rstw_stray1", stray_cnt, 1);

    // 513 back-to-back reads: TID runs 0..511 then wraps to 0
    for (int i = 0; i < 513; i++) begin
      do_read(16'(2 * (i % 64)), 1, 1'b0, 1'b0, {32'(i), 32'($urandom)}, 0);
    end
    chk("wrap_tid", 64'(exp_tid), 1);

    // Randomized mix against the register model
    for (int i = 0; i < 60; i++) begin
      a  = 16'(2 * $urandom_range(0, 15));
      op = $urandom_range(0, 9);
      if ($urandom_range(0, 3) == 0) begin
        inject(TID_W'($urandom), 64'($urandom));
        exp_stray++;
        chk("rand_idle_stray", stray_cnt, 64'(exp_stray));
      end
      if (op < 4) begin
        d = {32'($urandom), 32'($urandom)};
        do_write(a, d, $urandom_range(0, 2));
      end else if (op < 8) begin
        d = mem.exists(int'(a)) ? mem[int'(a)] : 64'd0;
        do_read(a, $urandom_range(1, TO), ($urandom_range(0, 3) == 0), 1'b0, d,
                $urandom_range(0, 2));
      end else if (op == 8) begin
        do_odd(a | 16'd1, $urandom_range(0, 2));
      end else begin
        do_read(a, 1, 1'b0, 1'b1, 64'd0, $urandom_range(0, 2));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mmio_requester.md
Name: mmio_requester

Overview:
- Synthesizable MMIO initiator: the host end of the CCI-P MMIO path.
- Converts simple read/write commands into single-cycle MMIO request pulses that drive an AFU's Rx c0 MMIO fields.
- Matches the AFU's Tx c2 read responses by TID and returns completions on a valid/ready channel, with a timeout.
- Used in loopback self-test harnesses and on-chip exercisers of AFU register maps.

Parameters:
- TIMEOUT_CYCLES, 256: WAIT cycles allowed before a read completes with timeout; legal range 2..65535.
- TID_W, 9: width of the transaction ID.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  requester can accept a command.
- cmd_write  in  1  1 = MMIO write, 0 = MMIO read.
- cmd_addr  in  16  MMIO address in 32-bit word units; 64-bit registers sit at even addresses.
- cmd_wdata  in  64  write data.
- req_mmio_wr_valid  out  1  one-cycle write request pulse to the AFU.
- req_mmio_rd_valid  out  1  one-cycle read request pulse to the AFU.
- req_addr  out  16  request address.
- req_tid  out  TID_W  request TID.
- req_data  out  64  write data; 0 for reads.
- afu_rd_valid  in  1  AFU read response valid (Tx c2 mmioRdValid).
- afu_rd_tid  in  TID_W  AFU response TID.
- afu_rd_data  in  64  AFU response data.
- rsp_valid  out  1  completion valid.
- rsp_ready  in  1  completion consumed.
- rsp_data  out  64  read data; 0 for writes, errors and timeouts.
- rsp_timeout  out  1  read timed out.
- rsp_error  out  1  command rejected.
- stray_cnt  out  16  saturating count of unmatched AFU responses.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. All outputs are registered except cmd_ready (decoded from state).
- Reset values:
  - State is IDLE.
  - All req_* outputs are 0, tid counter is 0, and rsp_* outputs are 0.
  - stray_cnt is 0.
  - cmd_ready is 1 in the first cycle after reset.
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: latch the command and go to ISSUE.
  - If cmd_addr[0]=1: go directly to DONE with rsp_error=1 and rsp_data=0. No request is issued and the tid counter is unchanged.
- ISSUE (exactly one cycle):
  - Exactly one of req_mmio_wr_valid / req_mmio_rd_valid is 1; req_addr and req_data are valid.
  - req_tid equals the tid counter.
  - Reads go to WAIT and increment the tid counter (wraps 2^TID_W-1 -> 0).
  - Writes go to DONE with rsp_data=0; the tid counter is unchanged.
- WAIT:
  - Timer starts at 0 on entry and increments each cycle.
  - On afu_rd_valid with afu_rd_tid matching the latched TID: capture afu_rd_data and go to DONE.
  - If timer = TIMEOUT_CYCLES-1 with no match: go to DONE with rsp_timeout=1, rsp_data=0.
  - A match in the same cycle as expiry counts as a match, not a timeout.
- DONE:
  - rsp_valid=1; rsp_data, rsp_timeout and rsp_error are held stable until rsp_ready.
  - On rsp_ready, clear rsp_* and go to IDLE. cmd_ready therefore returns one cycle after the rsp handshake.
- Latency: a read with a 1-cycle AFU response has rsp_valid 3 cycles after cmd acceptance. A write has rsp_valid 2 cycles after acceptance.
- Stray responses: afu_rd_valid in any state other than WAIT, or in WAIT with a mismatched TID, increments stray_cnt (saturates at 16'hFFFF). It never completes a command, and a WAIT with a mismatched TID keeps waiting.
- Timed-out reads: a response arriving after its read timed out is stray.
- One outstanding command at a time. cmd_* inputs are ignored outside IDLE.
- Reset mid-operation:
  - Any state returns to IDLE; the pending completion is discarded; tid returns to 0; stray_cnt is cleared.
  - A response arriving after reset for a pre-reset request is counted as stray.

Test Plan:
- Read at 0x0000; responder returns 64'h1000_0100_0000_0000 with the matching TID 1 cycle after the pulse -> req_mmio_rd_valid is a single 1-cycle pulse with req_tid=0; rsp_valid 3 cycles after accept, rsp_data=64'h1000_0100_0000_0000, timeout=0, error=0.
- Write 0x0020 data 64'hDEAD_BEEF_0000_0001, then read 0x0020 with a FIFO-model responder -> write completes with rsp_data=0 and no TID increment; read returns 64'hDEAD_BEEF_0000_0001 with req_tid=0.
- Read with a silent responder and TIMEOUT_CYCLES=8 -> rsp_timeout=1 and rsp_data=0 after exactly 8 WAIT cycles. A response injected 2 cycles later -> stray_cnt=1.
- Read where the responder first returns TID+1, then the correct TID 3 cycles later -> stray_cnt=1, correct data returned, no premature completion.
- Read at odd address 0x0003 -> no req pulse, rsp_error=1 one cycle after accept, tid counter unchanged.
- 513 back-to-back reads -> req_tid runs 0..511 then 0. Separately, rst asserted in WAIT -> next cycle IDLE, cmd_ready=1, tid=0; the later response increments stray_cnt to 1.
